hv_decoder: RTL and testbench

HV_DECODER -- requirements
Module: hv_decoder

---
 rtl/hv_decoder_pkg.sv | 21 ++
 rtl/hv_decoder_popcount.sv | 18 +
 rtl/hv_decoder.sv | 118 +++++++++++
 tb/tb_hv_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_decoder_pkg.sv
// Shared hypervector definitions: default width, distance width, word type and decoder FSM states.
// DIM defaults to 64 unless the `DIM macro is supplied by the build.
`ifndef DIM
`define DIM 64
`endif

package hv_decoder_pkg;

  localparam int unsigned HV_DIM    = `DIM;
  localparam int unsigned HV_DIST_W = $clog2(HV_DIM) + 1;

  typedef logic [HV_DIM-1:0]    dw_t;
  typedef logic [HV_DIST_W-1:0] dist_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/hv_decoder_popcount.sv
// Combinational population count; output is wide enough to represent WIDTH itself.
module popcount #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]       i_data,
  output logic [$clog2(WIDTH):0] o_count
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end

endmodule

// File: rtl/hv_decoder.sv
// Associative-memory decoder: unbinds a query, scans the item memory for the nearest entry.
// Optional HV_DECODER_THRESH_EN registers r_miss = (r_dist > THRE); otherwise r_miss is tied low.
`ifndef DIM
`define DIM 64
`endif

module hv_decoder
  import hv_decoder_pkg::*;
#(
  parameter int unsigned DIM      = `DIM,
  parameter int unsigned ITEM_NUM = 16,
  parameter int unsigned THRE     = DIM / 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        im_wr,
  input  logic [$clog2(ITEM_NUM)-1:0] im_addr,
  input  logic [DIM-1:0]              im_data,
  output logic                        im_rdy,
  input  logic                        q_valid,
  output logic                        q_ready,
  input  logic [DIM-1:0]              q_hv,
  input  logic [DIM-1:0]              q_key,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [$clog2(ITEM_NUM)-1:0] r_index,
  output logic [$clog2(DIM):0]        r_dist,
  output logic                        r_miss
);

  localparam int unsigned AW = $clog2(ITEM_NUM);
  localparam int unsigned DW = $clog2(DIM) + 1;

  state_t          r_state, w_next;
  logic [DIM-1:0]  r_u;
  logic [AW-1:0]   r_cnt;
  logic            r_last;
  logic [DW-1:0]   r_best_dist;
  logic [AW-1:0]   r_best_idx;
  logic [DIM-1:0]  r_im [ITEM_NUM];
  logic [DW-1:0]   w_dist;
  logic            w_accept;
  logic            w_commit;

  assign q_ready  = (r_state == ST_IDLE);
  assign im_rdy   = (r_state == ST_IDLE);
  assign r_valid  = (r_state == ST_DONE);
  assign w_accept = q_valid && q_ready && !clr;
  // The cycle after the last entry is compared copies the winner to the outputs.
  assign w_commit = (r_state == ST_SCAN) && r_last && !clr;

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (q_valid) w_next = ST_SCAN;
        ST_SCAN: if (r_last)  w_next = ST_DONE;
        ST_DONE: if (r_ready) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (im_wr && im_rdy) r_im[im_addr] <= im_data;
  end

  popcount #(.WIDTH(DIM)) u_popcount (
    .i_data  (r_u ^ r_im[r_cnt]),
    .o_count (w_dist)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_u         <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_index     <= '0;
      r_dist      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_u         <= q_hv ^ q_key;
        r_cnt       <= '0;
        r_last      <= 1'b0;
        r_best_dist <= '1;
        r_best_idx  <= '0;
      end else if ((r_state == ST_SCAN) && !r_last) begin
        if (w_dist < r_best_dist) begin
          r_best_dist <= w_dist;
          r_best_idx  <= r_cnt;
        end
        if (r_cnt == AW'(ITEM_NUM - 1)) r_last <= 1'b1;
        else                            r_cnt  <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        r_index <= r_best_idx;
        r_dist  <= r_best_dist;
      end
    end
  end

`ifdef HV_DECODER_THRESH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_miss <= 1'b0;
    else if (w_commit) r_miss <= (r_best_dist > DW'(THRE));
  end
`else
  assign r_miss = 1'b0;
`endif

endmodule

// File: tb/tb_hv_decoder.sv
// Self-checking bench for hv_decoder: nearest-item model with cycle-level timing expectations.
`timescale 1ns/1ps
module tb_hv_decoder;

  localparam int DIM  = 64;
  localparam int N    = 4;
  localparam int THRE = 16;
  localparam int LAT  = N + 1;

  logic        clk = 1'b0;
  logic        rst_n, clr, im_wr, q_valid, r_ready;
  logic [1:0]  im_addr;
  logic [63:0] im_data, q_hv, q_key;
  logic        im_rdy, q_ready, r_valid, r_miss;
  logic [1:0]  r_index;
  logic [6:0]  r_dist;

  hv_decoder #(.DIM(DIM), .ITEM_NUM(N), .THRE(THRE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .im_wr(im_wr), .im_addr(im_addr), .im_data(im_data), .im_rdy(im_rdy),
    .q_valid(q_valid), .q_ready(q_ready), .q_hv(q_hv), .q_key(q_key),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_index(r_index), .r_dist(r_dist), .r_miss(r_miss)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: item memory, busy flag and accept time; result from a plain nearest search.
  logic [63:0] m_im [N];
  bit          busy = 1'b0;
  int          cyc = 0, acc = 0;
  int          e_idx, e_dist;
  bit          e_miss;

  function automatic void predict(logic [63:0] u);
    e_dist = DIM + 1;
    e_idx  = 0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = $countones(u ^ m_im[i]);
      if (d < e_dist) begin
        e_dist = d;
        e_idx  = i;
      end
    end
`ifdef HV_DECODER_THRESH_EN
    e_miss = (e_dist > THRE);
`else
    e_miss = 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      bit rv_prev;
      cyc++;
      rv_prev = busy && ((cyc - 1) >= acc + LAT);
      if (!busy && im_wr) m_im[im_addr] = im_data;
      if (clr) busy = 1'b0;
      else if (!busy) begin
        if (q_valid) begin
          busy = 1'b1;
          acc  = cyc;
          predict(q_hv ^ q_key);
        end
      end else if (rv_prev && r_ready) busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit exp_rv;
      exp_rv = busy && (cyc >= acc + LAT);
      chk("q_ready", q_ready, !busy);
      chk("im_rdy", im_rdy, !busy);
      chk("r_valid", r_valid, exp_rv);
      if (exp_rv) begin
        chk("r_index", r_index, e_idx);
        chk("r_dist", r_dist, e_dist);
        chk("r_miss", r_miss, e_miss);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    im_wr = 1'b1; im_addr = a; im_data = d;
    tick();
    im_wr = 1'b0;
  endtask

  task automatic send(input logic [63:0] hv, input logic [63:0] key);
    q_valid = 1'b1; q_hv = hv; q_key = key;
    tick();
    q_valid = 1'b0;
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    while (!r_valid && n < 40) begin
      tick();
      n++;
    end
    if (!r_valid) chk("rv_timeout", r_valid, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; im_wr = 1'b0; im_addr = '0; im_data = '0;
    q_valid = 1'b0; q_hv = '0; q_key = '0; r_ready = 1'b1;
    tick(); tick();
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_index", r_index, 0);
    chk("rst_r_dist", r_dist, 0);
    chk("rst_r_miss", r_miss, 0);
    rst_n = 1'b1;
    chk("rst_q_ready", q_ready, 1);
    chk("rst_im_rdy", im_rdy, 1);

    // Nearest exact match at the last entry.
    wr(0, 64'h0); wr(1, '1); wr(2, 64'h00000000FFFFFFFF); wr(3, 64'hFFFF);
    send(64'hFFFF, 64'h0);
    wait_rv(n);
    chk("lat_basic", n, LAT);
    chk("basic_index", r_index, 3);
    chk("basic_dist", r_dist, 0);
    tick();
    chk("basic_back_idle", q_ready, 1);

    // Back-pressure: result held, writes dropped.
    r_ready = 1'b0;
    send(64'hFFFF, 64'h0);
    wait_rv(n);
    for (int i = 0; i < 10; i++) begin
      im_wr = 1'b1; im_addr = 2'd0; im_data = '1;
      chk("hold_q_ready", q_ready, 0);
      chk("hold_r_valid", r_valid, 1);
      chk("hold_index", r_index, 3);
      tick();
    end
    im_wr = 1'b0; r_ready = 1'b1;
    tick();

    // Tie between entries 0 and 2 at distance 0; a leaked write to IM[0] would pick 2.
    wr(2, 64'h0);
    send(64'h123456789ABCDEF0, 64'h123456789ABCDEF0);
    wait_rv(n);
    chk("tie_index", r_index, 0);
    chk("tie_dist", r_dist, 0);
    tick();

    // Abort in the second scan cycle.
    send(64'hFFFF, 64'h0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_q_ready", q_ready, 1);
    chk("clr_r_valid", r_valid, 0);
    repeat (6) tick();
    chk("clr_no_result", r_valid, 0);
    send(64'hFFFF, 64'h0);
    wait_rv(n);
    chk("lat_after_clr", n, LAT);
    chk("after_clr_index", r_index, 3);
    tick();

    // Threshold boundary: nearest distance 20, then 16.
    wr(0, 64'h00000000000FFFFF); wr(1, '1); wr(2, 64'h000000FFFFFFFFFF); wr(3, 64'h00000000FFFFFFFF);
    send(64'h0, 64'h0);
    wait_rv(n);
    chk("d20_dist", r_dist, 20);
`ifdef HV_DECODER_THRESH_EN
    chk("d20_miss", r_miss, 1);
`else
    chk("d20_miss", r_miss, 0);
`endif
    tick();
    wr(0, 64'hFFFF);
    send(64'h0, 64'h0);
    wait_rv(n);
    chk("d16_dist", r_dist, 16);
    chk("d16_miss", r_miss, 0);
    tick();

    // Reset mid-scan: immediate abandon, IM retained.
    send(64'hFFFF, 64'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_r_valid", r_valid, 0);
    chk("rst_mid_q_ready", q_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_rel_q_ready", q_ready, 1);
    send(64'hFFFF, 64'h0);
    wait_rv(n);
    chk("retained_index", r_index, 0);
    chk("retained_dist", r_dist, 0);
    tick();

    // Randomized traffic with back-pressure, aborts and dropped writes.
    for (int it = 0; it < 60; it++) begin
      logic [63:0] hv, key, u;
      int guard;
      hv = {$urandom, $urandom};
      key = {$urandom, $urandom};
      u = hv ^ key;
      repeat ($urandom_range(0, 3)) begin
        logic [63:0] d;
        d = ($urandom % 3 == 0) ? {$urandom, $urandom}
                                : u ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        wr(2'($urandom), d);
        if ($urandom % 4 == 0) wr(2'($urandom), d);
      end
      send(hv, key);
      guard = 0;
      while (guard < 60) begin
        r_ready = $urandom_range(0, 1);
        q_valid = $urandom_range(0, 1);
        clr = ($urandom % 25 == 0);
        im_wr = ($urandom % 4 == 0); im_addr = 2'($urandom); im_data = {$urandom, $urandom};
        tick();
        clr = 1'b0; im_wr = 1'b0; q_valid = 1'b0;
        guard++;
        if (q_ready) break;
      end
      if (!q_ready) chk("rand_drain", q_ready, 1);
      r_ready = 1'b1;
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
